// File: rtl/sdm_mash_dwa_if.sv
// Control and output bundle of the fine-loop MASH modulator.
// The master side drives controls; the slave side (modulator) drives the codes.
interface sdm_mash_dwa_if #(
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 3,
    parameter int THRM_W = 7
);
    logic              sdm_on;
    logic [1:0]        sdm_order;
    logic [FRAC_W-1:0] frac_in;
    logic              frac_vld;
    logic              dither_en;
    logic              sdm_man_on;
    logic [OUT_W-1:0]  sdm_man_val;
    logic              sdm_thrm_en;
    logic              dwa_en;
    logic [OUT_W-1:0]  out_bin;
    logic [THRM_W-1:0] out_thrm;

    modport master (
        output sdm_on, sdm_order, frac_in, frac_vld, dither_en,
               sdm_man_on, sdm_man_val, sdm_thrm_en, dwa_en,
        input  out_bin, out_thrm
    );

    modport slave (
        input  sdm_on, sdm_order, frac_in, frac_vld, dither_en,
               sdm_man_on, sdm_man_val, sdm_thrm_en, dwa_en,
        output out_bin, out_thrm
    );
endinterface

// File: rtl/sdm_mash_dwa.sv
// MASH 1-1-1 sigma-delta modulator with run-time order, LFSR dither, manual
// override and a thermometer output with optional DWA rotation.
module sdm_mash_dwa #(
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 3,
    parameter int THRM_W = 7,
    parameter int OFFSET = 3
) (
    input  logic           nsh_clk,
    input  logic           rst_n,
    sdm_mash_dwa_if.slave  bus
);
    logic [FRAC_W-1:0] frac_r, acc1, acc2, acc3;
    logic              c2_d1, c3_d1, c3_d2;
    logic [1:0]        order_q;
    logic [OUT_W-1:0]  ptr, ptr_n;
    logic [14:0]       lfsr;
    logic [OUT_W-1:0]  out_bin_q, bin_n;
    logic [THRM_W-1:0] out_thrm_q, thrm_n, base, rot;

    logic              run, ord_chg, d;
    logic              c1, c2, c3;
    logic [FRAC_W:0]   s1, s2, s3;
    logic [3:0]        y;
    int unsigned       psum;

    assign run     = bus.sdm_on && (bus.sdm_order != 2'd0);
    assign ord_chg = (bus.sdm_order != order_q);
    assign d       = lfsr[0] & bus.dither_en;

    assign s1 = {1'b0, acc1} + {1'b0, frac_r} + {{FRAC_W{1'b0}}, d};
    assign s2 = {1'b0, acc2} + {1'b0, s1[FRAC_W-1:0]};
    assign s3 = {1'b0, acc3} + {1'b0, s2[FRAC_W-1:0]};
    assign c1 = s1[FRAC_W];
    assign c2 = s2[FRAC_W];
    assign c3 = s3[FRAC_W];

    // Modulo-16 arithmetic is enough: the true sum is -3..+4, so y+OFFSET fits 0..7.
    always_comb begin
        y = 4'd0;
        case (bus.sdm_order)
            2'd1: y = {3'b000, c1};
            2'd2: y = {3'b000, c1} + {3'b000, c2} - {3'b000, c2_d1};
            2'd3: y = {3'b000, c1} + {3'b000, c2} - {3'b000, c2_d1}
                    + {3'b000, c3} - {2'b00, c3_d1, 1'b0} + {3'b000, c3_d2};
            default: y = 4'd0;
        endcase
    end

    always_comb begin
        bin_n = OUT_W'(OFFSET);
        if (bus.sdm_man_on)
            bin_n = bus.sdm_man_val;
        else if (run && !ord_chg)
            bin_n = OUT_W'(y + 4'(OFFSET));
    end

    // DWA: K ones rotated left by ptr inside the THRM_W-bit ring.
    always_comb begin
        base = ~({THRM_W{1'b1}} << bin_n);
        rot  = (base << ptr) | (base >> (THRM_W - int'(ptr)));
        psum = int'(ptr) + int'(bin_n);

        thrm_n = '0;
        if (bus.sdm_thrm_en)
            thrm_n = bus.dwa_en ? rot : base;

        ptr_n = ptr;
        if (!run || ord_chg || (bus.sdm_thrm_en && !bus.dwa_en))
            ptr_n = '0;
        else if (bus.sdm_thrm_en)
            ptr_n = OUT_W'((psum >= THRM_W) ? psum - THRM_W : psum);
    end

    always_ff @(posedge nsh_clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_r     <= '0;
            acc1       <= '0;
            acc2       <= '0;
            acc3       <= '0;
            c2_d1      <= 1'b0;
            c3_d1      <= 1'b0;
            c3_d2      <= 1'b0;
            order_q    <= 2'd0;
            ptr        <= '0;
            lfsr       <= 15'h0001;
            out_bin_q  <= OUT_W'(OFFSET);
            out_thrm_q <= '0;
        end else begin
            order_q    <= bus.sdm_order;
            out_bin_q  <= bin_n;
            out_thrm_q <= thrm_n;
            ptr        <= ptr_n;
            lfsr       <= run ? {lfsr[13:0], lfsr[14] ^ lfsr[13]} : 15'h0001;
            if (bus.frac_vld)
                frac_r <= bus.frac_in;
            if (!run || ord_chg) begin
                acc1  <= '0;
                acc2  <= '0;
                acc3  <= '0;
                c2_d1 <= 1'b0;
                c3_d1 <= 1'b0;
                c3_d2 <= 1'b0;
            end else begin
                // Stages above the selected order stay parked at zero.
                acc1  <= s1[FRAC_W-1:0];
                acc2  <= (bus.sdm_order >= 2'd2) ? s2[FRAC_W-1:0] : '0;
                acc3  <= (bus.sdm_order == 2'd3) ? s3[FRAC_W-1:0] : '0;
                c2_d1 <= (bus.sdm_order >= 2'd2) && c2;
                c3_d1 <= (bus.sdm_order == 2'd3) && c3;
                c3_d2 <= (bus.sdm_order == 2'd3) && c3_d1;
            end
        end
    end

    assign bus.out_bin  = out_bin_q;
    assign bus.out_thrm = out_thrm_q;
endmodule

// File: tb/tb_sdm_mash_dwa.sv
// Self-checking bench for sdm_mash_dwa: behavioural model feeding a scoreboard
// queue, a DWA vector table and directed sequences for reset/order-change cases.
module tb_sdm_mash_dwa;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdm_mash_dwa_if bus ();
    sdm_mash_dwa dut (.nsh_clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int bin;
        int thrm;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [2:0] val;
        logic [6:0] thrm;
    } dwa_vec_t;
    dwa_vec_t tbl[8];

    int n_cmp = 0;
    int n_err = 0;

    int m_acc1, m_acc2, m_acc3, m_c2d, m_c3d1, m_c3d2;
    int m_ordq, m_ptr, m_lfsr, m_frac;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int popcnt(input logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
        m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
        m_ordq = 0; m_ptr = 0; m_lfsr = 1; m_frac = 0;
    endtask

    // Advance the reference by one edge using the inputs currently driven.
    task automatic model_step();
        int o, run, chg, dd, s1, s2, s3, c1, c2, c3, y, k, t, fb;
        exp_t e;
        o   = int'(bus.sdm_order);
        run = (bus.sdm_on && o != 0) ? 1 : 0;
        chg = (o != m_ordq) ? 1 : 0;
        dd  = (m_lfsr & 1) & int'(bus.dither_en);
        s1 = m_acc1 + m_frac + dd;     c1 = s1 / 256;
        s2 = m_acc2 + (s1 % 256);      c2 = s2 / 256;
        s3 = m_acc3 + (s2 % 256);      c3 = s3 / 256;
        y = c1;
        if (o >= 2) y += c2 - m_c2d;
        if (o == 3) y += c3 - 2 * m_c3d1 + m_c3d2;

        if (bus.sdm_man_on)      e.bin = int'(bus.sdm_man_val);
        else if (run && !chg)    e.bin = y + 3;
        else                     e.bin = 3;

        k = e.bin;
        t = 0;
        if (bus.sdm_thrm_en) begin
            if (!bus.dwa_en) t = (1 << k) - 1;
            else for (int j = 0; j < k; j++) t |= 1 << ((m_ptr + j) % 7);
        end
        e.thrm = t;

        if (!run || chg)                         m_ptr = 0;
        else if (bus.sdm_thrm_en && !bus.dwa_en) m_ptr = 0;
        else if (bus.sdm_thrm_en)                m_ptr = (m_ptr + k) % 7;

        if (!run || chg) begin
            m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
            m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
        end else begin
            m_c3d2 = (o == 3) ? m_c3d1 : 0;
            m_c3d1 = (o == 3) ? c3 : 0;
            m_c2d  = (o >= 2) ? c2 : 0;
            m_acc1 = s1 % 256;
            m_acc2 = (o >= 2) ? s2 % 256 : 0;
            m_acc3 = (o == 3) ? s3 % 256 : 0;
        end
        if (run) begin
            fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 32'h7fff;
        end else begin
            m_lfsr = 1;
        end
        if (bus.frac_vld) m_frac = int'(bus.frac_in);
        m_ordq = o;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_bin", 32'(bus.out_bin), 32'(e.bin));
        chk("sb_thrm", 32'(bus.out_thrm), 32'(e.thrm));
    endtask

    initial begin
        int sum;
        tbl[0] = '{3'd3, 7'b0000111};
        tbl[1] = '{3'd3, 7'b0111000};
        tbl[2] = '{3'd3, 7'b1000011};
        tbl[3] = '{3'd3, 7'b0011100};
        tbl[4] = '{3'd7, 7'b1111111};
        tbl[5] = '{3'd1, 7'b0100000};
        tbl[6] = '{3'd0, 7'b0000000};
        tbl[7] = '{3'd2, 7'b1000001};

        bus.sdm_on = 1'b0; bus.sdm_order = 2'd0; bus.frac_in = '0; bus.frac_vld = 1'b0;
        bus.dither_en = 1'b0; bus.sdm_man_on = 1'b0; bus.sdm_man_val = '0;
        bus.sdm_thrm_en = 1'b0; bus.dwa_en = 1'b0;
        model_reset();

        // Reset state, then release with modulator off.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bin", 32'(bus.out_bin), 32'd3);
        chk("rst_thrm", 32'(bus.out_thrm), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("off_bin", 32'(bus.out_bin), 32'd3);
        end

        // Order 1, half-scale input.
        bus.sdm_order = 2'd1;
        tick();
        bus.sdm_on = 1'b1; bus.frac_in = 8'h80; bus.frac_vld = 1'b1;
        tick();
        bus.frac_vld = 1'b0;
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i < 4) chk("o1_seq", 32'(bus.out_bin), (i % 2 == 1) ? 32'd4 : 32'd3);
            sum += int'(bus.out_bin);
        end
        chk("o1_sum", 32'(sum), 32'd896);

        // Asynchronous reset mid-run with thermometer active.
        bus.sdm_thrm_en = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_bin", 32'(bus.out_bin), 32'd3);
        chk("async_thrm", 32'(bus.out_thrm), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Order 3, quarter-scale input, plain thermometer.
        bus.sdm_order = 2'd3; bus.frac_in = 8'h40; bus.frac_vld = 1'b1;
        tick();
        bus.frac_vld = 1'b0;
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("o3_pop", 32'(popcnt(bus.out_thrm)), 32'(bus.out_bin));
            sum += int'(bus.out_bin) - 3;
        end
        chk("o3_sum_in_band", (sum >= 61 && sum <= 67) ? 32'd1 : 32'd0, 32'd1);

        // DWA rotation under manual override.
        bus.sdm_man_on = 1'b1; bus.dwa_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.sdm_man_val = tbl[i].val;
            tick();
            chk("dwa_bin", 32'(bus.out_bin), 32'(tbl[i].val));
            chk("dwa_thrm", 32'(bus.out_thrm), 32'(tbl[i].thrm));
        end
        bus.sdm_man_on = 1'b0; bus.dwa_en = 1'b0;

        // Order change mid-run, then order 0.
        repeat (20) tick();
        bus.sdm_order = 2'd2;
        tick();
        chk("chg_bin", 32'(bus.out_bin), 32'd3);
        chk("chg_acc1", 32'(dut.acc1), 32'd0);
        chk("chg_acc2", 32'(dut.acc2), 32'd0);
        chk("chg_acc3", 32'(dut.acc3), 32'd0);
        repeat (20) tick();
        bus.sdm_order = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ord0_bin", 32'(bus.out_bin), 32'd3);
        end

        // Override release with dither and DWA: model keeps running underneath.
        bus.sdm_order = 2'd2; bus.frac_in = 8'h5B; bus.frac_vld = 1'b1;
        bus.dither_en = 1'b1; bus.sdm_man_on = 1'b1; bus.sdm_man_val = 3'd5;
        bus.dwa_en = 1'b1;
        tick();
        bus.frac_vld = 1'b0;
        repeat (99) tick();
        bus.sdm_man_on = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
